// File: rtl/kcuart_rx_if.sv
// Serial line, frame configuration and received-byte bus of the kcuart receiver.
// The line side (master) drives config and serial input; the receiver (slave) drives results.
interface kcuart_rx_if;
  logic       msb_first_i;
  logic       parity_en_i;
  logic       start_polarity_i;
  logic       serial_in_i;
  logic       en_16x_baud_i;
  logic [7:0] data_out_o;
  logic       data_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  modport master (
    output msb_first_i,
    output parity_en_i,
    output start_polarity_i,
    output serial_in_i,
    output en_16x_baud_i,
    input  data_out_o,
    input  data_valid_o,
    input  parity_err_o,
    input  frame_err_o,
    input  busy_o
  );

  modport slave (
    input  msb_first_i,
    input  parity_en_i,
    input  start_polarity_i,
    input  serial_in_i,
    input  en_16x_baud_i,
    output data_out_o,
    output data_valid_o,
    output parity_err_o,
    output frame_err_o,
    output busy_o
  );
endinterface

// File: rtl/kcuart_rx.sv
// Compact 16x-oversampling UART receiver: start/data/parity/stop validation, one strobe per frame.
// Optional build macro KCUART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around SAMPLE_POINT, decisions at SAMPLE_POINT+1.
module kcuart_rx #(
  parameter int SAMPLE_POINT = 7
) (
  input  logic       clk,
  input  logic       rst,
  kcuart_rx_if.slave bus
);

`ifdef KCUART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] LP_DECIDE_TICK = 4'(SAMPLE_POINT + 1);
`else
  localparam logic [3:0] LP_DECIDE_TICK = 4'(SAMPLE_POINT);
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic f_even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic f_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t     r_state, w_state_n;
  logic       r_sync1, r_sync2;
  logic [3:0] r_baud_cnt, w_baud_cnt_n;
  logic [2:0] r_bit_idx, w_bit_idx_n;
  logic [7:0] r_shift, w_shift_n;
  logic       r_par_err, w_par_err_n;
  logic       r_msb_first, w_msb_first_n;
  logic       r_parity_en, w_parity_en_n;
  logic       r_start_pol, w_start_pol_n;
  logic [7:0] r_data_out, w_data_out_n;
  logic       r_parity_err, w_parity_err_n;
  logic       r_frame_err, w_frame_err_n;
  logic       r_busy, w_busy_n;
  logic       r_data_valid;
  logic       w_strobe;
  logic       w_decide;
  logic       w_bit;
  logic [2:0] w_wr_idx;

`ifdef KCUART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;

  // Samples from the two ticks before the decision tick, for the vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= {2{~bus.start_polarity_i}};
    end else if (bus.en_16x_baud_i) begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  assign w_bit = f_maj3(r_hist[1], r_hist[0], r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  // Two-flop synchronizer; reset to the idle (stop) level so no false start follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= ~bus.start_polarity_i;
      r_sync2 <= ~bus.start_polarity_i;
    end else begin
      r_sync1 <= bus.serial_in_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_decide = (r_baud_cnt == LP_DECIDE_TICK);
  assign w_wr_idx = r_msb_first ? (3'd7 - r_bit_idx) : r_bit_idx;

  // Next-state and next-value logic, evaluated for the current en tick.
  always_comb begin
    w_state_n      = r_state;
    w_baud_cnt_n   = r_baud_cnt + 4'd1;
    w_bit_idx_n    = r_bit_idx;
    w_shift_n      = r_shift;
    w_par_err_n    = r_par_err;
    w_msb_first_n  = r_msb_first;
    w_parity_en_n  = r_parity_en;
    w_start_pol_n  = r_start_pol;
    w_data_out_n   = r_data_out;
    w_parity_err_n = r_parity_err;
    w_frame_err_n  = r_frame_err;
    w_busy_n       = r_busy;
    w_strobe       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_baud_cnt_n = 4'd0;
        if (r_sync2 == bus.start_polarity_i) begin
          w_state_n     = ST_START;
          w_busy_n      = 1'b1;
          w_bit_idx_n   = 3'd0;
          w_par_err_n   = 1'b0;
          w_msb_first_n = bus.msb_first_i;
          w_parity_en_n = bus.parity_en_i;
          w_start_pol_n = bus.start_polarity_i;
        end else begin
          w_state_n = ST_IDLE;
        end
      end

      ST_START: begin
        if (w_decide && (w_bit != r_start_pol)) begin
          w_state_n    = ST_IDLE;
          w_busy_n     = 1'b0;
          w_baud_cnt_n = 4'd0;
        end else if (r_baud_cnt == 4'd15) begin
          w_state_n   = ST_DATA;
          w_bit_idx_n = 3'd0;
        end else begin
          w_state_n = ST_START;
        end
      end

      ST_DATA: begin
        if (w_decide) begin
          w_shift_n[w_wr_idx] = w_bit;
        end else begin
          w_shift_n = r_shift;
        end
        if (r_baud_cnt == 4'd15) begin
          w_bit_idx_n = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_n = r_parity_en ? ST_PARITY : ST_STOP;
          end else begin
            w_state_n = ST_DATA;
          end
        end else begin
          w_state_n = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (w_decide) begin
          w_par_err_n = (w_bit != f_even_parity(r_shift));
        end else begin
          w_par_err_n = r_par_err;
        end
        if (r_baud_cnt == 4'd15) begin
          w_state_n = ST_STOP;
        end else begin
          w_state_n = ST_PARITY;
        end
      end

      // Leaving at mid-stop lets the next start edge be caught right after the stop bit.
      ST_STOP: begin
        if (w_decide) begin
          w_strobe       = 1'b1;
          w_data_out_n   = r_shift;
          w_parity_err_n = r_par_err;
          w_frame_err_n  = (w_bit == r_start_pol);
          w_busy_n       = 1'b0;
          w_baud_cnt_n   = 4'd0;
          w_state_n      = (w_bit == r_start_pol) ? ST_WAIT_IDLE : ST_IDLE;
        end else begin
          w_state_n = ST_STOP;
        end
      end

      ST_WAIT_IDLE: begin
        w_baud_cnt_n = 4'd0;
        if (r_sync2 != r_start_pol) begin
          w_state_n = ST_IDLE;
        end else begin
          w_state_n = ST_WAIT_IDLE;
        end
      end

      default: begin
        w_state_n    = ST_IDLE;
        w_busy_n     = 1'b0;
        w_baud_cnt_n = 4'd0;
      end
    endcase
  end

  // Frame state, counters and result registers advance only on en ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_baud_cnt   <= 4'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_par_err    <= 1'b0;
      r_msb_first  <= 1'b0;
      r_parity_en  <= 1'b0;
      r_start_pol  <= 1'b0;
      r_data_out   <= 8'h00;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else if (bus.en_16x_baud_i) begin
      r_state      <= w_state_n;
      r_baud_cnt   <= w_baud_cnt_n;
      r_bit_idx    <= w_bit_idx_n;
      r_shift      <= w_shift_n;
      r_par_err    <= w_par_err_n;
      r_msb_first  <= w_msb_first_n;
      r_parity_en  <= w_parity_en_n;
      r_start_pol  <= w_start_pol_n;
      r_data_out   <= w_data_out_n;
      r_parity_err <= w_parity_err_n;
      r_frame_err  <= w_frame_err_n;
      r_busy       <= w_busy_n;
    end
  end

  // Single-clock strobe in the cycle after the stop decision tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_strobe & bus.en_16x_baud_i;
    end
  end

  assign bus.data_out_o   = r_data_out;
  assign bus.data_valid_o = r_data_valid;
  assign bus.parity_err_o = r_parity_err;
  assign bus.frame_err_o  = r_frame_err;
  assign bus.busy_o       = r_busy;

endmodule
